// File: rtl/reg_mask_encoder_pkg.sv
// Shared constants, FSM state type and helpers for reg_mask_encoder.
// Imported by prio_enc32 and reg_mask_encoder.
package reg_mask_encoder_pkg;

    localparam int REG_MASK_W = 32;
    localparam int REG_IDX_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // True when exactly one bit is set.
    function automatic logic is_single(input logic [REG_MASK_W-1:0] v);
        return (v != '0) && ((v & (v - REG_MASK_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/reg_mask_encoder_prio.sv
// prio_enc32: combinational lowest-set-bit encoder.
// Ports: mask (32b in), idx (5b out, lowest set bit), any (out, mask != 0).
module prio_enc32
    import reg_mask_encoder_pkg::*;
(
    input  logic [REG_MASK_W-1:0] mask,
    output logic [REG_IDX_W-1:0]  idx,
    output logic                  any
);

    // Scan from the top down so the lowest set bit is written last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = REG_MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = REG_IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_mask_encoder.sv
// Serialises a 32-bit register-select mask into 5-bit indices, lowest first.
// Ports: clk, rst_n (async low); load_valid/load_ready/load_mask accept a mask
// while idle; flush aborts; idx_valid/idx_ready/idx_out/idx_last drain the
// indices; done pulses one cycle after the mask is exhausted.
// Build option: define REG0_SKIP_EN to drop bit 0 ($zero) at capture.
module reg_mask_encoder
    import reg_mask_encoder_pkg::*;
#(
    parameter int WIDTH = REG_MASK_W,
    parameter int IDX_W = REG_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_mask,
    input  logic             flush,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_last,
    output logic             done
);

    state_e           state_q;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic [WIDTH-1:0] capture_d;
    logic             done_q;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             busy;
    logic             last;

    prio_enc32 u_enc (
        .mask (pending_q),
        .idx  (enc_idx),
        .any  (enc_any)
    );

    always_comb begin
        capture_d = load_mask;
`ifdef REG0_SKIP_EN
        capture_d[0] = 1'b0;
`endif
    end

    // Clearing the lowest set bit is the same as retiring enc_idx.
    assign pending_d = pending_q & (pending_q - WIDTH'(1));

    assign busy = (state_q == BUSY);
    assign last = is_single(pending_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q   <= IDLE;
                pending_q <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (load_valid) begin
                            pending_q <= capture_d;
                            if (capture_d != '0) begin
                                state_q <= BUSY;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    BUSY: begin
                        if (idx_ready) begin
                            pending_q <= pending_d;
                            if (last) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // Outputs depend only on registered state, never on inputs.
    assign load_ready = !busy;
    assign idx_valid  = busy;
    assign idx_out    = (busy && enc_any) ? enc_idx : '0;
    assign idx_last   = busy && last;
    assign done       = done_q;

endmodule

// File: tb/tb_reg_mask_encoder.sv
// Scoreboard bench for reg_mask_encoder.
// Directed cases plus randomized masks and consumer backpressure.
module tb_reg_mask_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_mask = '0;
    logic        flush = 1'b0;
    logic        idx_valid;
    logic        idx_ready = 1'b0;
    logic [4:0]  idx_out;
    logic        idx_last;
    logic        done;

    reg_mask_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_mask  (load_mask),
        .flush      (flush),
        .idx_valid  (idx_valid),
        .idx_ready  (idx_ready),
        .idx_out    (idx_out),
        .idx_last   (idx_last),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int idx;
        bit last;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    bit   rand_rdy = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: list the set bits of the effective mask in ascending
    // order; the last listed one carries the last flag; then a done.
    function automatic void push_mask(input logic [31:0] m);
        logic [31:0] eff;
        int n;
        int k;
        eff = m;
`ifdef REG0_SKIP_EN
        eff[0] = 1'b0;
`endif
        n = 0;
        k = 0;
        for (int i = 0; i < 32; i++) if (eff[i]) n++;
        for (int i = 0; i < 32; i++) begin
            if (eff[i]) begin
                k++;
                q.push_back('{1'b0, i, (k == n)});
            end
        end
        q.push_back('{1'b1, 0, 1'b0});
    endfunction

    // Monitor: pops one expectation per DUT output event.
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            if (idx_valid && idx_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL idx_unexpected: got idx %0d", idx_out);
                end else begin
                    e = q.pop_front();
                    if (e.is_done || idx_out !== 5'(e.idx) ||
                        idx_last !== e.last) begin
                        fails++;
                        $display("FAIL idx: got %0d last %0b expected %s %0d last %0b",
                                 idx_out, idx_last,
                                 e.is_done ? "done" : "idx", e.idx, e.last);
                    end
                end
            end
            if (done) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL done_unexpected: got done 1 expected 0");
                end else begin
                    e = q.pop_front();
                    if (!e.is_done) begin
                        fails++;
                        $display("FAIL done_early: got done expected idx %0d",
                                 e.idx);
                    end
                end
                chk("done_load_ready", 32'(load_ready), 32'd1);
                chk("done_idx_valid", 32'(idx_valid), 32'd0);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) idx_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] m);
        int n;
        n = 0;
        while (!load_ready && n < 200) begin
            step();
            n++;
        end
        chk("load_ready_timeout", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_mask  = m;
        push_mask(m);
        step();
        load_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
        step();
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_load_ready"}, 32'(load_ready), 32'd1);
        chk({nm, "_idx_valid"}, 32'(idx_valid), 32'd0);
        chk({nm, "_idx_out"}, 32'(idx_out), 32'd0);
        chk({nm, "_idx_last"}, 32'(idx_last), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
    endtask

    logic [31:0] m;
    int          n;

    initial begin
        #12;
        chk_reset_outs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // 0x16 drains 1,2,4 back to back, then done with load_ready.
        idx_ready = 1'b1;
        load(32'h0000_0016);
        chk("a_idx0", 32'(idx_out), 32'd1);
        step();
        chk("a_idx1", 32'(idx_out), 32'd2);
        chk("a_last1", 32'(idx_last), 32'd0);
        step();
        chk("a_idx2", 32'(idx_out), 32'd4);
        chk("a_last2", 32'(idx_last), 32'd1);
        step();
        chk("a_done", 32'(done), 32'd1);
        chk("a_ready", 32'(load_ready), 32'd1);
        wait_drain();

        load(32'h8000_0001);
        wait_drain();

        // Stall: 8 holds for 4 cycles, then 9 with last.
        idx_ready = 1'b0;
        load(32'h0000_0300);
        chk("c_valid", 32'(idx_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("c_stall_idx", 32'(idx_out), 32'd8);
            chk("c_stall_last", 32'(idx_last), 32'd0);
            step();
        end
        idx_ready = 1'b1;
        chk("c_idx8", 32'(idx_out), 32'd8);
        step();
        chk("c_idx9", 32'(idx_out), 32'd9);
        chk("c_last9", 32'(idx_last), 32'd1);
        wait_drain();

        // Empty mask: done right after acceptance, no index.
        load(32'h0);
        chk("d_done", 32'(done), 32'd1);
        chk("d_valid", 32'(idx_valid), 32'd0);
        step();
        chk("d_done_off", 32'(done), 32'd0);
        wait_drain();

        // Full mask; a load offered during the drain is refused.
        load(32'hFFFF_FFFF);
        load_valid = 1'b1;
        load_mask  = 32'h0000_0003;
        for (int i = 0; i < 5; i++) begin
            chk("e_busy_ready", 32'(load_ready), 32'd0);
            step();
        end
        load_valid = 1'b0;
        wait_drain();

        // Flush after index 5 has been taken.
        load(32'h0000_00F0);
        n = 0;
        while (!(idx_valid && idx_out == 5'd5) && n < 50) begin
            step();
            n++;
        end
        chk("f_saw5", 32'(idx_out), 32'd5);
        step();
        flush      = 1'b1;
        idx_ready  = 1'b0;
        load_valid = 1'b1;
        load_mask  = 32'h0000_0003;
        step();
        flush      = 1'b0;
        load_valid = 1'b0;
        q.delete();
        chk("f_valid", 32'(idx_valid), 32'd0);
        chk("f_ready", 32'(load_ready), 32'd1);
        chk("f_done", 32'(done), 32'd0);
        step();
        chk("f_done2", 32'(done), 32'd0);

        // Flush while idle wins over a simultaneous load.
        flush      = 1'b1;
        load_valid = 1'b1;
        load_mask  = 32'h0000_0005;
        step();
        flush      = 1'b0;
        load_valid = 1'b0;
        chk("fi_valid", 32'(idx_valid), 32'd0);
        chk("fi_done", 32'(done), 32'd0);
        step();
        chk("fi_valid2", 32'(idx_valid), 32'd0);
        chk("fi_done2", 32'(done), 32'd0);

        // Asynchronous reset in the middle of a drain.
        idx_ready = 1'b1;
        load(32'h0000_00F0);
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_mid");
        q.delete();
        #1;
        rst_n = 1'b1;
        step();
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(idx_valid), 32'd0);

        // Random masks under random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: m = 32'h0;
                1: m = 32'h1 << $urandom_range(0, 31);
                2: m = $urandom & $urandom & $urandom;
                default: m = $urandom;
            endcase
            load(m);
            if ($urandom_range(0, 3) == 0) wait_drain();
        end
        wait_drain();
        rand_rdy = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
